spi_master_2ss: RTL and testbench
=================================

SPI_MASTER_2SS -- requirements
Module: spi_master_2ss

Interface
REQ-001 Parameter CLK_DIV, default 2, SHALL set the sclk half-period in clk cycles; legal range 2..255.
REQ-002 Parameter DATA_W, default 8, SHALL set the bits per transfer; legal range 2..32.
REQ-003 clk  input  1  SHALL be the single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-005 start  input  1  SHALL be the request strobe; sampled on each clk edge.
REQ-006 sel  input  1  SHALL pick the slave: 0 = ss1, 1 = ss2.
REQ-007 tx_data  input  DATA_W  SHALL hold the word to shift out, MSB first.
REQ-008 miso  input  1  SHALL carry the shared slave return line.
REQ-009 sclk  output  1  SHALL be the serial clock; SPI mode 0, idles low.
REQ-010 mosi  output  1  SHALL be the serial data out.
REQ-011 ss1  output  1  SHALL be the slave-1 select, active-high, matching the slave-side tristate enable.
REQ-012 ss2  output  1  SHALL be the slave-2 select, active-high.
REQ-013 rx_data  output  DATA_W  SHALL hold the last received word.
REQ-014 busy  output  1  SHALL be high while a transfer is in progress.
REQ-015 done  output  1  SHALL be a one-cycle pulse at the end of each transfer.

Function
REQ-016 FSM states SHALL be IDLE, SETUP, XFER and HOLD.
REQ-017 IDLE: start=1 at edge T0 SHALL latch sel and tx_data and move to SETUP; all other inputs are ignored in IDLE.
REQ-018 start SHALL be ignored whenever busy=1; no queuing.
REQ-019 From T0+1: busy=1, the selected ss=1, mosi=tx_data[DATA_W-1], sclk=0; SETUP SHALL last CLK_DIV cycles.
REQ-020 XFER SHALL produce exactly DATA_W sclk pulses, each CLK_DIV cycles high then CLK_DIV cycles low.
REQ-021 miso SHALL be sampled into the shift register on the clk edge that drives sclk 0->1.
REQ-022 mosi SHALL advance to the next bit on the edge that drives sclk 1->0, except after the last bit.
REQ-023 After the last falling edge, HOLD SHALL keep ss asserted and sclk low for CLK_DIV cycles.
REQ-024 At T0+1+CLK_DIV*(2*DATA_W+2) the FSM SHALL return to IDLE in the same edge that: ss1=ss2=0, busy=0, done=1 for one cycle, rx_data=received word (first sampled bit = MSB).
REQ-025 rx_data SHALL change only on a done edge or on reset.
REQ-026 start=1 in the done cycle SHALL be accepted (back-to-back); ss SHALL stay low for at least that one cycle.
REQ-027 ss1 and ss2 SHALL never be high together; the unselected ss SHALL stay low for the whole transfer.
REQ-028 mosi SHALL be 0 whenever no ss is asserted.
REQ-029 The half-period counter SHALL wrap from CLK_DIV-1 to 0; the bit counter SHALL saturate at DATA_W and never wrap mid-transfer.

Reset
REQ-030 rst=1 SHALL, without waiting for clk, force: state IDLE, sclk=0, mosi=0, ss1=0, ss2=0, busy=0, done=0, rx_data=0, and clear all counters.
REQ-031 Reset during a transfer SHALL abort it with no done pulse; rx_data SHALL read 0.
REQ-032 After rst falls, the first start SHALL behave exactly as after power-up.

Verification
REQ-033 CLK_DIV=2, DATA_W=8, sel=0, tx_data=0xA5, slave returns 0x3C -> ss1 high T0+1..T0+36; mosi at the 8 rising edges = 1,0,1,0,0,1,0,1; done at T0+37; rx_data=0x3C; ss2 low throughout.
REQ-034 sel=1, tx_data=0xFF, miso held 0 -> ss2 high for 36 cycles, mosi=1 at every rising edge, rx_data=0x00, ss1 never high.
REQ-035 start re-pulsed at T0+10 with tx_data=0x11 -> ignored; transfer completes with the 0xA5 waveform; exactly one done pulse.
REQ-036 rst pulsed asynchronously between clk edges at the 4th sclk high phase -> all outputs reach their reset values before the next clk edge; no done pulse; next transfer is correct.
REQ-037 start held high through the done cycle -> second transfer starts at done+1; ss low exactly one cycle between transfers; both rx_data values correct.

Source files
------------

// File: rtl/spi_master_2ss.sv
`default_nettype none
// ============================================================================
// Module      : spi_master_2ss
// Description : SPI mode-0 master driving two active-high slave selects.
//               Each transfer runs a SETUP phase, DATA_W sclk pulses (MSB
//               first in both directions) and a HOLD phase, then pulses done.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_master_2ss #(
    parameter int CLK_DIV = 2,
    parameter int DATA_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              sel,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              miso,
    output logic              sclk,
    output logic              mosi,
    output logic              ss1,
    output logic              ss2,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              done
);

    localparam int              c_BW       = $clog2(DATA_W + 1);
    localparam logic [7:0]      c_DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [c_BW-1:0] c_BITS     = c_BW'(DATA_W);
    localparam logic [c_BW-1:0] c_BITS_M1  = c_BW'(DATA_W - 1);
    localparam logic [c_BW-1:0] c_BIT_ONE  = c_BW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        XFER  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t            state_q;
    logic [7:0]        div_q;
    logic [7:0]        div_d;
    logic              div_last;
    logic [c_BW-1:0]   bit_q;
    logic [DATA_W-1:0] tx_q;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] rx_q;
    logic              sclk_q;
    logic              ss1_q;
    logic              ss2_q;
    logic              busy_q;
    logic              done_q;

    // Half-period counter: wraps from CLK_DIV-1 back to 0.
    always_comb begin
        div_last = (div_q == c_DIV_LAST);
        div_d    = div_last ? 8'd0 : div_q + 8'd1;
    end

    // Transfer sequencer; every output comes straight from a register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= 8'd0;
            bit_q   <= '0;
            tx_q    <= '0;
            shift_q <= '0;
            rx_q    <= '0;
            sclk_q  <= 1'b0;
            ss1_q   <= 1'b0;
            ss2_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= SETUP;
                        tx_q    <= tx_data;
                        ss1_q   <= ~sel;
                        ss2_q   <= sel;
                        busy_q  <= 1'b1;
                        div_q   <= 8'd0;
                        bit_q   <= '0;
                        shift_q <= '0;
                        sclk_q  <= 1'b0;
                    end
                end
                SETUP: begin
                    div_q <= div_d;
                    if (div_last) begin
                        // First rising sclk edge: capture the slave's MSB.
                        sclk_q  <= 1'b1;
                        shift_q <= {shift_q[DATA_W-2:0], miso};
                        state_q <= XFER;
                    end
                end
                XFER: begin
                    div_q <= div_d;
                    if (div_last) begin
                        if (sclk_q) begin
                            // Falling edge: one more bit complete.
                            sclk_q <= 1'b0;
                            if (bit_q != c_BITS) begin
                                bit_q <= bit_q + c_BIT_ONE;
                            end
                            // Present the next bit unless this was the last one.
                            if (bit_q < c_BITS_M1) begin
                                tx_q <= {tx_q[DATA_W-2:0], 1'b0};
                            end
                        end else if (bit_q == c_BITS) begin
                            state_q <= HOLD;
                        end else begin
                            sclk_q  <= 1'b1;
                            shift_q <= {shift_q[DATA_W-2:0], miso};
                        end
                    end
                end
                HOLD: begin
                    div_q <= div_d;
                    if (div_last) begin
                        state_q <= IDLE;
                        ss1_q   <= 1'b0;
                        ss2_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        rx_q    <= shift_q;
                        tx_q    <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign sclk    = sclk_q;
    assign mosi    = tx_q[DATA_W-1];
    assign ss1     = ss1_q;
    assign ss2     = ss2_q;
    assign rx_data = rx_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_2ss.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_spi_master_2ss
// Description : Scoreboard bench for spi_master_2ss with a behavioural slave
//               and a transfer-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master_2ss;

    localparam int CLK_DIV = 2;
    localparam int DATA_W  = 8;
    localparam int N       = CLK_DIV * (2 * DATA_W + 2);

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              sel;
    logic [DATA_W-1:0] tx_data;
    logic              miso = 1'b0;
    logic              sclk;
    logic              mosi;
    logic              ss1;
    logic              ss2;
    logic [DATA_W-1:0] rx_data;
    logic              busy;
    logic              done;

    spi_master_2ss #(.CLK_DIV(CLK_DIV), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .start(start), .sel(sel), .tx_data(tx_data),
        .miso(miso), .sclk(sclk), .mosi(mosi), .ss1(ss1), .ss2(ss2),
        .rx_data(rx_data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DATA_W-1:0] tx;
        logic              s;
        logic [DATA_W-1:0] slv;
        int                e;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   next_free = 0;
    int   both_bad = 0;
    int   idle_bad = 0;
    int   rx_bad = 0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endfunction

    // Behavioural mode-0 slave: MSB ready at select, next bit after each sclk fall.
    logic [DATA_W-1:0] sl_word = '0;
    logic [DATA_W-1:0] mosi_cap = '0;
    int                sl_idx = 0;
    logic              sl_ss_p = 1'b0;
    logic              sl_sclk_p = 1'b0;
    always @(negedge clk) begin
        if ((ss1 || ss2) && !sl_ss_p) begin
            sl_word  = (exp_q.size() != 0) ? exp_q[0].slv : '0;
            sl_idx   = 0;
            mosi_cap = '0;
        end
        if (sclk && !sl_sclk_p) mosi_cap = {mosi_cap[DATA_W-2:0], mosi};
        if (!sclk && sl_sclk_p) sl_idx++;
        miso      = (sl_idx < DATA_W) ? sl_word[DATA_W-1-sl_idx] : 1'b0;
        sl_ss_p   = ss1 || ss2;
        sl_sclk_p = sclk;
    end

    // Monitor: accumulates per-transfer observations and scores them at done.
    int   ss_cyc, wrong_ss, rises, hi_cyc, busy_cyc;
    logic prev_ss, prev_sclk;
    logic [DATA_W-1:0] prev_rx;
    exp_t cur;
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            ss_cyc = 0; wrong_ss = 0; rises = 0; hi_cyc = 0; busy_cyc = 0;
            prev_ss = 1'b0; prev_sclk = 1'b0; prev_rx = '0;
        end else begin
            if (ss1 && ss2) both_bad++;
            if (!ss1 && !ss2 && (mosi || sclk)) idle_bad++;
            if (rx_data !== prev_rx && !done) rx_bad++;
            prev_rx = rx_data;
            if ((ss1 || ss2) && !prev_ss) begin
                if (exp_q.size() == 0) chk("unexpected_ss_rise", 64'd1, 64'd0);
                else chk("ss_rise_edge", 64'(cyc), 64'(exp_q[0].e));
                ss_cyc = 0; wrong_ss = 0; rises = 0; hi_cyc = 0; busy_cyc = 0;
            end
            if (exp_q.size() != 0) begin
                if (exp_q[0].s ? ss2 : ss1) ss_cyc++;
                if (exp_q[0].s ? ss1 : ss2) wrong_ss++;
            end
            if (sclk && !prev_sclk) rises++;
            if (sclk) hi_cyc++;
            if (busy) busy_cyc++;
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    cur = exp_q.pop_front();
                    chk("rx_data", 64'(rx_data), 64'(cur.slv));
                    chk("mosi_word", 64'(mosi_cap), 64'(cur.tx));
                    chk("done_latency", 64'(cyc - cur.e), 64'(N));
                    chk("ss_high_cycles", 64'(ss_cyc), 64'(N));
                    chk("other_ss_cycles", 64'(wrong_ss), 64'd0);
                    chk("sclk_pulses", 64'(rises), 64'(DATA_W));
                    chk("sclk_high_cycles", 64'(hi_cyc), 64'(DATA_W * CLK_DIV));
                    chk("busy_cycles", 64'(busy_cyc), 64'(N));
                    chk("busy_at_done", 64'(busy), 64'd0);
                end
            end else if (exp_q.size() != 0 && cyc > exp_q[0].e + N + 2) begin
                chk("done_timeout", 64'(cyc - exp_q[0].e), 64'(N));
                void'(exp_q.pop_front());
            end
            prev_ss   = ss1 || ss2;
            prev_sclk = sclk;
        end
    end

    // Reference model: a start is accepted only once the previous transfer's done cycle is reached.
    function automatic void model_edge(input logic [DATA_W-1:0] tx, input logic s,
                                       input logic [DATA_W-1:0] slv, output bit acc);
        exp_t x;
        acc = 1'b0;
        if (cyc >= next_free) begin
            x.tx = tx; x.s = s; x.slv = slv; x.e = cyc;
            exp_q.push_back(x);
            next_free = cyc + N + 1;
            acc = 1'b1;
        end
    endfunction

    task automatic issue(input logic [DATA_W-1:0] tx, input logic s, input logic [DATA_W-1:0] slv);
        bit acc;
        start = 1'b1; tx_data = tx; sel = s;
        @(posedge clk); #1;
        model_edge(tx, s, slv, acc);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_free();
        for (int k = 0; k < 4 * N && cyc < next_free + 1; k++) @(negedge clk);
    endtask

    initial begin
        bit acc;
        int n_acc;
        int n_rise;
        logic was;
        logic [DATA_W-1:0] slv_b;

        rst = 1'b1; start = 1'b0; sel = 1'b0; tx_data = '0;
        #1;
        chk("reset_outputs", 64'({sclk, mosi, ss1, ss2, busy, done, rx_data}), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        issue(8'hA5, 1'b0, 8'h3C);
        wait_free();
        issue(8'hFF, 1'b1, 8'h00);
        wait_free();

        // Restart attempt ten cycles into a transfer must be ignored.
        issue(8'hA5, 1'b0, 8'h3C);
        repeat (9) @(negedge clk);
        issue(8'h11, 1'b0, 8'h77);
        wait_free();

        // Asynchronous reset in the 4th sclk high phase.
        issue(8'($urandom), 1'($urandom), 8'($urandom));
        n_rise = 0;
        was = sclk;
        for (int k = 0; k < 4 * N && n_rise < 4; k++) begin
            @(posedge clk); #1;
            if (sclk && !was) n_rise++;
            was = sclk;
        end
        chk("sclk_rise_wait", 64'(n_rise), 64'd4);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_outputs", 64'({sclk, mosi, ss1, ss2, busy, done, rx_data}), 64'd0);
        exp_q.delete();
        next_free = 0;
        rst = 1'b0;
        @(negedge clk);
        issue(8'h5A, 1'b1, 8'hC3);
        wait_free();

        // start held high through the done cycle: two back-to-back transfers.
        slv_b = 8'($urandom);
        start = 1'b1; tx_data = 8'h96; sel = 1'b0;
        n_acc = 0;
        for (int k = 0; k < 3 * N && n_acc < 2; k++) begin
            @(posedge clk); #1;
            if (n_acc == 0) model_edge(tx_data, sel, 8'h69, acc);
            else model_edge(tx_data, sel, slv_b, acc);
            if (acc) begin
                n_acc++;
                tx_data = 8'($urandom);
                sel = 1'b1;
            end
        end
        chk("b2b_accepts", 64'(n_acc), 64'd2);
        @(negedge clk);
        start = 1'b0;
        wait_free();

        // Randomised traffic, sometimes starting while busy.
        for (int t = 0; t < 12; t++) begin
            if ($urandom_range(0, 2) != 0) wait_free();
            repeat ($urandom_range(0, 20)) @(negedge clk);
            issue(8'($urandom), 1'($urandom), 8'($urandom));
        end
        wait_free();
        repeat (3) @(negedge clk);

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        chk("both_ss_high", 64'(both_bad), 64'd0);
        chk("idle_mosi_sclk", 64'(idle_bad), 64'd0);
        chk("rx_change_without_done", 64'(rx_bad), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
